// File: rtl/cpu7_mem_arb.sv
// rtl/cpu7_mem_arb.sv - round-robin multi-channel memory request arbiter with in-order response routing
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   ch_req/addr/wr/wstrb/wdata      per-channel request fields (channel i in slice i)
//   ch_cancel                       per-channel cancel pulse: discard that channel's pending responses
//   ch_addr_ok, ch_data_ok          per-channel accept / response strobes (one-hot or zero)
//   ch_rdata                        response data shared by all channels
//   mem_req/addr/wr/wstrb/wdata     merged downstream request
//   mem_addr_ok                     downstream accepted the request this cycle
//   mem_data_ok, mem_rdata          downstream in-order response
//   outst_cnt                       accepted-but-unanswered request count
//   err_resp                        sticky: response arrived with nothing outstanding
module cpu7_mem_arb #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OUTST  = 4,
  localparam int IDW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int PTR_W = (OUTST > 1) ? $clog2(OUTST) : 1,
  localparam int CNT_W = $clog2(OUTST + 1),
  localparam int SW    = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        ch_req,
  input  logic [NCH*ADDR_W-1:0] ch_addr,
  input  logic [NCH-1:0]        ch_wr,
  input  logic [NCH*SW-1:0]     ch_wstrb,
  input  logic [NCH*DATA_W-1:0] ch_wdata,
  input  logic [NCH-1:0]        ch_cancel,
  output logic [NCH-1:0]        ch_addr_ok,
  output logic [NCH-1:0]        ch_data_ok,
  output logic [DATA_W-1:0]     ch_rdata,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wr,
  output logic [SW-1:0]         mem_wstrb,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_addr_ok,
  input  logic                  mem_data_ok,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [CNT_W-1:0]      outst_cnt,
  output logic                  err_resp
);

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant;
  logic             any_req;
  logic             full;
  logic             empty;
  logic             accept;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [IDW-1:0]   tag_id [OUTST];
  logic [OUTST-1:0] tag_disc;
  logic [IDW-1:0]   head_id;
  logic [IDW-1:0]   next_ptr;

  // Round-robin search starting at rr_ptr, wrapping modulo NCH.
  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && ch_req[idx]) begin
        grant = IDW'(idx);
        found = 1'b1;
      end
    end
  end

  assign any_req = |ch_req;
  assign full    = (outst_cnt == CNT_W'(OUTST));
  assign empty   = (outst_cnt == '0);

  // Full uses the pre-edge count, so a same-cycle pop cannot open a slot.
  assign mem_req = any_req && !full && !reset;
  assign accept  = mem_req && mem_addr_ok;

  always_comb begin
    mem_addr  = '0;
    mem_wr    = 1'b0;
    mem_wstrb = '0;
    mem_wdata = '0;
    if (any_req) begin
      mem_addr  = ch_addr[grant*ADDR_W +: ADDR_W];
      mem_wr    = ch_wr[grant];
      mem_wstrb = ch_wstrb[grant*SW +: SW];
      mem_wdata = ch_wdata[grant*DATA_W +: DATA_W];
    end
  end

  assign ch_addr_ok = accept ? (NCH'(1) << grant) : '0;

  assign head_id  = tag_id[rd_ptr];
  assign pop      = mem_data_ok && !empty && !reset;
  // A cancel arriving in the pop cycle suppresses that response too.
  assign ch_data_ok = (pop && !tag_disc[rd_ptr] && !ch_cancel[head_id])
                      ? (NCH'(1) << head_id) : '0;
  assign ch_rdata = mem_rdata;

  assign next_ptr = (grant == IDW'(NCH - 1)) ? '0 : grant + IDW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      outst_cnt <= '0;
      tag_disc  <= '0;
      err_resp  <= 1'b0;
    end else begin
      for (int j = 0; j < OUTST; j++) begin
        if (ch_cancel[tag_id[j]]) tag_disc[j] <= 1'b1;
      end
      if (accept) begin
        // Written after the cancel sweep so a stale flag in this slot is overwritten,
        // while a same-cycle cancel for the granted channel still marks it.
        tag_id[wr_ptr]   <= grant;
        tag_disc[wr_ptr] <= ch_cancel[grant];
        wr_ptr           <= wr_ptr + PTR_W'(1);
        rr_ptr           <= next_ptr;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   outst_cnt <= outst_cnt + CNT_W'(1);
        2'b01:   outst_cnt <= outst_cnt - CNT_W'(1);
        default: outst_cnt <= outst_cnt;
      endcase
      if (mem_data_ok && empty) err_resp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu7_mem_arb.sv
// tb/tb_cpu7_mem_arb.sv - scoreboard bench for cpu7_mem_arb
module tb_cpu7_mem_arb;

  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    ch_req;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH-1:0]    ch_wr;
  logic [NCH*SW-1:0] ch_wstrb;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH-1:0]    ch_cancel;
  logic [NCH-1:0]    ch_addr_ok;
  logic [NCH-1:0]    ch_data_ok;
  logic [DW-1:0]     ch_rdata;
  logic              mem_req;
  logic [AW-1:0]     mem_addr;
  logic              mem_wr;
  logic [SW-1:0]     mem_wstrb;
  logic [DW-1:0]     mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DW-1:0]     mem_rdata;
  logic [2:0]        outst_cnt;
  logic              err_resp;

  cpu7_mem_arb dut (
    .clk(clk), .reset(reset),
    .ch_req(ch_req), .ch_addr(ch_addr), .ch_wr(ch_wr), .ch_wstrb(ch_wstrb),
    .ch_wdata(ch_wdata), .ch_cancel(ch_cancel),
    .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .outst_cnt(outst_cnt), .err_resp(err_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] ok;
    logic [AW-1:0]  addr;
    logic           wr;
    logic [SW-1:0]  strb;
    logic [DW-1:0]  wdata;
  } acc_t;

  typedef struct {
    logic [NCH-1:0] ok;
    logic [DW-1:0]  rdata;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Fixed per-channel write attributes.
  logic           c_wr   [NCH] = '{1'b0, 1'b1};
  logic [SW-1:0]  c_strb [NCH] = '{4'h3, 4'hF};
  logic [DW-1:0]  c_wdata[NCH] = '{32'h0000_BEEF, 32'hDEAD_0001};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic set_addr(input int ch, input logic [AW-1:0] a);
    ch_addr[ch*AW +: AW] = a;
  endtask

  task automatic exp_acc(input int ch, input logic [AW-1:0] a);
    acc_t e;
    e.ok    = NCH'(1) << ch;
    e.addr  = a;
    e.wr    = c_wr[ch];
    e.strb  = c_strb[ch];
    e.wdata = c_wdata[ch];
    acc_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic [NCH-1:0] ok, input logic [DW-1:0] d);
    rsp_t r;
    r.ok    = ok;
    r.rdata = d;
    rsp_q.push_back(r);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes an accept or a response.
  always @(negedge clk) begin
    if (!reset) begin
      if (ch_addr_ok != '0) begin
        checks++;
        if (acc_q.size() == 0) begin
          failures++;
          $display("FAIL accept_unexpected got ch_addr_ok=%b exp none", ch_addr_ok);
        end else begin
          acc_t e;
          e = acc_q.pop_front();
          if ({ch_addr_ok, mem_addr, mem_wr, mem_wstrb, mem_wdata} !==
              {e.ok, e.addr, e.wr, e.strb, e.wdata}) begin
            failures++;
            $display("FAIL accept got ok=%b addr=%h wr=%b strb=%h wd=%h exp ok=%b addr=%h wr=%b strb=%h wd=%h",
                     ch_addr_ok, mem_addr, mem_wr, mem_wstrb, mem_wdata,
                     e.ok, e.addr, e.wr, e.strb, e.wdata);
          end
        end
      end
      if (ch_data_ok != '0) begin
        checks++;
        if (rsp_q.size() == 0) begin
          failures++;
          $display("FAIL response_unexpected got ch_data_ok=%b exp none", ch_data_ok);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          if ({ch_data_ok, ch_rdata} !== {r.ok, r.rdata}) begin
            failures++;
            $display("FAIL response got ok=%b rdata=%h exp ok=%b rdata=%h",
                     ch_data_ok, ch_rdata, r.ok, r.rdata);
          end
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    ch_req      = '0;
    ch_addr     = '0;
    ch_cancel   = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    for (int c = 0; c < NCH; c++) begin
      ch_wr[c]             = c_wr[c];
      ch_wstrb[c*SW +: SW] = c_strb[c];
      ch_wdata[c*DW +: DW] = c_wdata[c];
    end
    repeat (3) @(posedge clk);
    #1;

    // Outputs forced low during reset, even with requests and a response present.
    ch_req = 2'b11; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    set_addr(0, 32'h1000); set_addr(1, 32'h2000);
    #1;
    chk("reset_mem_req", mem_req, 0);
    chk("reset_addr_ok", ch_addr_ok, 0);
    chk("reset_data_ok", ch_data_ok, 0);
    tick();
    chk("reset_outst", outst_cnt, 0);
    chk("reset_err", err_resp, 0);

    // Round robin: grants alternate starting at channel 0, filling the FIFO.
    reset = 1'b0; mem_data_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_acc(i % 2, (i % 2 == 0) ? 32'h1000 : 32'h2000);
      tick();
    end
    chk("full_outst", outst_cnt, 4);
    chk("full_mem_req", mem_req, 0);
    tick();
    // Pop while full: no accept this cycle.
    mem_data_ok = 1'b1; mem_rdata = 32'hA0;
    exp_rsp(2'b01, 32'hA0);
    #1;
    chk("full_pop_mem_req", mem_req, 0);
    tick();
    mem_data_ok = 1'b0;
    chk("after_pop_outst", outst_cnt, 3);
    exp_acc(0, 32'h1000);
    tick();
    ch_req = 2'b00;
    #1;
    chk("idle_mem_addr", mem_addr, 0);
    chk("idle_mem_wdata", mem_wdata, 0);
    mem_data_ok = 1'b1;
    mem_rdata = 32'hB1; exp_rsp(2'b10, 32'hB1); tick();
    mem_rdata = 32'hB2; exp_rsp(2'b01, 32'hB2); tick();
    mem_rdata = 32'hB3; exp_rsp(2'b10, 32'hB3); tick();
    mem_rdata = 32'hB4; exp_rsp(2'b01, 32'hB4); tick();
    mem_data_ok = 1'b0;
    chk("drain_outst", outst_cnt, 0);

    // Response ordering across channels.
    ch_req = 2'b10; set_addr(1, 32'h100); exp_acc(1, 32'h100); tick();
    ch_req = 2'b01; set_addr(0, 32'h200); exp_acc(0, 32'h200); tick();
    ch_req = 2'b00; mem_data_ok = 1'b1;
    mem_rdata = 32'h11; exp_rsp(2'b10, 32'h11); tick();
    mem_rdata = 32'h22; exp_rsp(2'b01, 32'h22); tick();
    mem_data_ok = 1'b0;

    // Cancel two pending channel-0 requests.
    set_addr(0, 32'h500);
    ch_req = 2'b01; exp_acc(0, 32'h500); tick();
    exp_acc(0, 32'h500); tick();
    ch_req = 2'b00; ch_cancel = 2'b01; tick();
    ch_cancel = 2'b00; mem_data_ok = 1'b1; mem_rdata = 32'hEE;
    tick(); tick();
    mem_data_ok = 1'b0;
    chk("cancel_outst", outst_cnt, 0);
    ch_req = 2'b01; exp_acc(0, 32'h500); tick();
    ch_req = 2'b00; mem_data_ok = 1'b1; mem_rdata = 32'h33; exp_rsp(2'b01, 32'h33); tick();
    mem_data_ok = 1'b0;

    // Cancel in the same cycle as the pop.
    ch_req = 2'b01; exp_acc(0, 32'h500); tick();
    ch_req = 2'b00; mem_data_ok = 1'b1; ch_cancel = 2'b01; tick();
    mem_data_ok = 1'b0; ch_cancel = 2'b00;
    // Cancel in the same cycle as the push; accept itself is unaffected.
    ch_req = 2'b01; ch_cancel = 2'b01; exp_acc(0, 32'h500); tick();
    ch_req = 2'b00; ch_cancel = 2'b00; mem_data_ok = 1'b1; tick();
    mem_data_ok = 1'b0;
    chk("cancel_pop_outst", outst_cnt, 0);

    // Unsolicited response.
    chk("err_before", err_resp, 0);
    mem_data_ok = 1'b1; tick();
    mem_data_ok = 1'b0;
    chk("err_set", err_resp, 1);
    tick(); tick();
    chk("err_held", err_resp, 1);

    // Reset with three outstanding, rr_ptr left at 1.
    set_addr(0, 32'h300); set_addr(1, 32'h400);
    ch_req = 2'b11; exp_acc(1, 32'h400); tick();
    exp_acc(0, 32'h300); tick();
    ch_req = 2'b01; exp_acc(0, 32'h300); tick();
    ch_req = 2'b00;
    chk("pre_reset_outst", outst_cnt, 3);
    reset = 1'b1; mem_data_ok = 1'b1; tick();
    reset = 1'b0; mem_data_ok = 1'b0;
    chk("post_reset_outst", outst_cnt, 0);
    chk("post_reset_err", err_resp, 0);
    ch_req = 2'b11; exp_acc(0, 32'h300); tick();
    ch_req = 2'b10; exp_acc(1, 32'h400); tick();
    ch_req = 2'b00;
    chk("post_reset_two", outst_cnt, 2);
    mem_data_ok = 1'b1;
    mem_rdata = 32'hC1; exp_rsp(2'b01, 32'hC1); tick();
    mem_rdata = 32'hC2; exp_rsp(2'b10, 32'hC2); tick();
    mem_data_ok = 1'b0;
    tick();
    chk("err_stays_clear", err_resp, 0);
    chk("acc_queue_empty", acc_q.size(), 0);
    chk("rsp_queue_empty", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
